// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - decode control fields, encodings, opcodes and immediate extractors
package decode_pkg;

  localparam logic [2:0] WB_NONE = 3'd0;
  localparam logic [2:0] WB_ALU  = 3'd1;
  localparam logic [2:0] WB_ALU2 = 3'd2;
  localparam logic [2:0] WB_LINK = 3'd3;
  localparam logic [2:0] WB_MEM  = 3'd4;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_AND = 2'd1;
  localparam logic [1:0] ALU_XOR = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  localparam logic [1:0] ALU2_SLL  = 2'd0;
  localparam logic [1:0] ALU2_SLT  = 2'd1;
  localparam logic [1:0] ALU2_SRL  = 2'd2;
  localparam logic [1:0] ALU2_PASS = 2'd3;

  localparam logic [4:0] OPC_LOAD      = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM  = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
  localparam logic [4:0] OPC_AUIPC     = 5'b00101;
  localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
  localparam logic [4:0] OPC_STORE     = 5'b01000;
  localparam logic [4:0] OPC_OP        = 5'b01100;
  localparam logic [4:0] OPC_LUI       = 5'b01101;
  localparam logic [4:0] OPC_OP_32     = 5'b01110;
  localparam logic [4:0] OPC_BRANCH    = 5'b11000;
  localparam logic [4:0] OPC_JALR      = 5'b11001;
  localparam logic [4:0] OPC_JAL       = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

  // Everything in the decode bundle except the XLEN-wide immediate, which sits above it.
  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu2_op;
    logic       alt_op;
    logic       alt2_op;
    logic [4:0] ra;
    logic [4:0] rb;
    logic [4:0] rd;
    logic       sel_pc_a;
    logic       sel_imm_b;
    logic       sel_imm_b2;
    logic [2:0] wb_sel;
    logic       mem;
    logic       mem_read;
    logic [2:0] mem_size;
    logic       branch;
    logic       jalr;
    logic [2:0] cmp;
    logic       illegal;
  } dec_ctl_t;

  localparam int CTL_W = $bits(dec_ctl_t);

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'd0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/decode_comb.sv
// rtl/decode_comb.sv - combinational RV32I/RV64I instruction word to decode bundle
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit CHK_ILL = 1'b1
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output dec_ctl_t        o_ctl
);

  localparam bit RV64 = (XLEN == 64);

  logic [4:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_rtype;
  logic        w_word;
  logic        w_alu_f3;
  logic [6:0]  w_shf;
  logic [31:0] w_imm32;
  logic        w_ill;
  dec_ctl_t    w_ctl;

  assign w_opc    = i_instr[6:2];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  assign w_rtype  = (w_opc == OPC_OP) || (w_opc == OPC_OP_32);
  assign w_word   = (w_opc == OPC_OP_IMM_32) || (w_opc == OPC_OP_32);
  assign w_alu_f3 = (w_f3 == 3'd0) || (w_f3 == 3'd4) || (w_f3 == 3'd6) || (w_f3 == 3'd7);
  // RV64 full-width shifts own instr[25] as shamt[5]; word and RV32 shifts do not.
  assign w_shf    = (RV64 && !w_word) ? {i_instr[31:26], 1'b0} : i_instr[31:25];

  always_comb begin
    w_imm32 = 32'd0;
    w_ill   = (i_instr[1:0] != 2'b11) || (w_word && !RV64);
    w_ctl   = '0;
    w_ctl.ra = i_instr[19:15];
    w_ctl.rb = i_instr[24:20];
    w_ctl.rd = i_instr[11:7];

    case (w_opc)
      OPC_OP_IMM, OPC_OP_IMM_32, OPC_OP, OPC_OP_32: begin
        w_imm32          = imm_i(i_instr);
        w_ctl.sel_imm_b  = !w_rtype;
        w_ctl.sel_imm_b2 = !w_rtype;
        w_ctl.alt_op     = w_rtype && (w_f7 == 7'h20);
        w_ctl.alt2_op    = i_instr[30];
        w_ctl.wb_sel     = w_alu_f3 ? WB_ALU : WB_ALU2;
        case (w_f3)
          3'd0:    w_ctl.alu_op  = ALU_ADD;
          3'd4:    w_ctl.alu_op  = ALU_XOR;
          3'd6:    w_ctl.alu_op  = ALU_OR;
          3'd7:    w_ctl.alu_op  = ALU_AND;
          3'd1:    w_ctl.alu2_op = ALU2_SLL;
          3'd5:    w_ctl.alu2_op = ALU2_SRL;
          default: w_ctl.alu2_op = ALU2_SLT;
        endcase
        if (w_word && (w_f3 != 3'd0) && (w_f3 != 3'd1) && (w_f3 != 3'd5)) w_ill = 1'b1;
        if (w_rtype) begin
          if ((w_f7 != 7'h00) && (w_f7 != 7'h20)) w_ill = 1'b1;
          if ((w_f7 == 7'h20) && (w_f3 != 3'd0) && (w_f3 != 3'd5)) w_ill = 1'b1;
        end else if ((w_f3 == 3'd1) || (w_f3 == 3'd5)) begin
          if ((w_shf != 7'h00) && !((w_shf == 7'h20) && (w_f3 == 3'd5))) w_ill = 1'b1;
        end
      end
      OPC_LOAD: begin
        w_imm32         = imm_i(i_instr);
        w_ctl.sel_imm_b = 1'b1;
        w_ctl.mem       = 1'b1;
        w_ctl.mem_read  = 1'b1;
        w_ctl.mem_size  = w_f3;
        w_ctl.wb_sel    = WB_MEM;
        if (w_f3 == 3'd7) w_ill = 1'b1;
        if (!RV64 && ((w_f3 == 3'd3) || (w_f3 == 3'd6))) w_ill = 1'b1;
      end
      OPC_STORE: begin
        w_imm32         = imm_s(i_instr);
        w_ctl.sel_imm_b = 1'b1;
        w_ctl.mem       = 1'b1;
        w_ctl.mem_size  = w_f3;
        if (w_f3 > (RV64 ? 3'd3 : 3'd2)) w_ill = 1'b1;
      end
      OPC_BRANCH: begin
        w_imm32         = imm_b(i_instr);
        w_ctl.branch    = 1'b1;
        w_ctl.cmp       = w_f3;
        w_ctl.sel_pc_a  = 1'b1;
        w_ctl.sel_imm_b = 1'b1;
        w_ctl.alu2_op   = ALU2_SLT;
        if ((w_f3 == 3'd2) || (w_f3 == 3'd3)) w_ill = 1'b1;
      end
      OPC_JAL: begin
        w_imm32         = imm_j(i_instr);
        w_ctl.branch    = 1'b1;
        w_ctl.sel_pc_a  = 1'b1;
        w_ctl.sel_imm_b = 1'b1;
        w_ctl.wb_sel    = WB_LINK;
      end
      OPC_JALR: begin
        w_imm32         = imm_i(i_instr);
        w_ctl.jalr      = 1'b1;
        w_ctl.branch    = 1'b1;
        w_ctl.sel_imm_b = 1'b1;
        w_ctl.wb_sel    = WB_LINK;
      end
      OPC_LUI: begin
        w_imm32          = imm_u(i_instr);
        w_ctl.alu2_op    = ALU2_PASS;
        w_ctl.ra         = 5'd0;
        w_ctl.sel_imm_b  = 1'b1;
        w_ctl.sel_imm_b2 = 1'b1;
        w_ctl.wb_sel     = WB_ALU2;
      end
      OPC_AUIPC: begin
        w_imm32         = imm_u(i_instr);
        w_ctl.sel_pc_a  = 1'b1;
        w_ctl.sel_imm_b = 1'b1;
        w_ctl.alu_op    = ALU_ADD;
        w_ctl.wb_sel    = WB_ALU;
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        w_imm32 = imm_i(i_instr);
      end
      default: w_ill = 1'b1;
    endcase

    if (!CHK_ILL) w_ill = 1'b0;
    // Illegal words still travel downstream so execute can trap, but with no side effects.
    if (w_ill) begin
      w_ctl.wb_sel   = WB_NONE;
      w_ctl.mem      = 1'b0;
      w_ctl.mem_read = 1'b0;
      w_ctl.branch   = 1'b0;
      w_ctl.jalr     = 1'b0;
    end
    if (w_ctl.rd == 5'd0) w_ctl.wb_sel = WB_NONE;
    w_ctl.illegal = w_ill;
  end

  assign o_imm = XLEN'($signed(w_imm32));
  assign o_ctl = w_ctl;

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with valid/ready handshakes, 2-entry skid and flush
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKID    = 1'b1,
  parameter bit CHK_ILL = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [31:0]           i_in_instr,
  input  logic [XLEN-1:0]       i_in_pc,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [XLEN-1:0]       o_out_pc,
  output logic [XLEN+CTL_W-1:0] o_dec_ctrl
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    dec_ctl_t        ctl;
  } dec_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} occ_e;

  occ_e            r_state;
  occ_e            w_next;
  logic            r_in_ready;
  dec_t            r_out_dec;
  dec_t            r_skid_dec;
  logic [XLEN-1:0] r_out_pc;
  logic [XLEN-1:0] r_skid_pc;

  logic [XLEN-1:0] w_imm;
  dec_ctl_t        w_ctl;
  dec_t            w_dec;
  logic            w_out_valid;
  logic            w_in_ready;
  logic            w_acc;
  logic            w_drain;
  logic            w_load_in;
  logic            w_load_skid;
  logic            w_fill_skid;

  // Decoding happens before the register so the output side is a plain flop.
  decode_comb #(
    .XLEN    (XLEN),
    .CHK_ILL (CHK_ILL)
  ) u_decode_comb (
    .i_instr (i_in_instr),
    .o_imm   (w_imm),
    .o_ctl   (w_ctl)
  );

  assign w_dec       = {w_imm, w_ctl};
  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_ready  = SKID ? r_in_ready : (!w_out_valid || i_out_ready);
  assign w_acc       = i_in_valid && w_in_ready && !i_flush;
  assign w_drain     = w_out_valid && i_out_ready;

  always_comb begin
    w_next      = r_state;
    w_load_in   = 1'b0;
    w_load_skid = 1'b0;
    w_fill_skid = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_acc) begin
          w_next    = ST_ONE;
          w_load_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_acc && w_drain) begin
          w_load_in = 1'b1;
        end else if (w_acc) begin
          w_next      = ST_TWO;
          w_fill_skid = 1'b1;
        end else if (w_drain) begin
          w_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_drain) begin
          w_next      = ST_ONE;
          w_load_skid = 1'b1;
        end
      end
      default: w_next = ST_EMPTY;
    endcase
    if (i_flush) w_next = ST_EMPTY;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
      r_out_dec  <= '0;
      r_out_pc   <= '0;
      r_skid_dec <= '0;
      r_skid_pc  <= '0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != ST_TWO);
      if (w_load_in) begin
        r_out_dec <= w_dec;
        r_out_pc  <= i_in_pc;
      end else if (w_load_skid) begin
        r_out_dec <= r_skid_dec;
        r_out_pc  <= r_skid_pc;
      end
      if (w_fill_skid) begin
        r_skid_dec <= w_dec;
        r_skid_pc  <= i_in_pc;
      end
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = w_out_valid;
  assign o_out_pc    = r_out_pc;
  assign o_dec_ctrl  = r_out_dec;

endmodule
